// File: rtl/serial_cla_adder.sv
// serial_cla_adder: multi-word adder that streams WIDTH-bit operands through a
// single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
// A registered carry links consecutive nibbles. Valid/ready handshakes on both
// sides; one operation in flight at a time, no input buffering.
module serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out,
    output logic             ovf_o
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;        // operand A, shifted right one nibble per step
    logic [WIDTH-1:0] b_q;        // operand B, shifted right one nibble per step
    logic [WIDTH-1:0] res_q;      // partial result, nibbles enter from the top
    logic [WIDTH-1:0] res_d;
    logic             carry_q;    // carry linking consecutive nibbles
    logic [CW-1:0]    cnt_q;      // index of the nibble being added
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    // Lookahead slice signals
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;

    // 4-bit carry-lookahead slice on the current operand nibbles and the carry register
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = p ^ c[3:0];
        // After NIB shifts the first nibble computed has reached bits [3:0].
        res_d              = res_q >> 4;
        res_d[WIDTH-1 -: 4] = s;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        carry_q    <= c_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ADD;
                    end
                end
                S_ADD: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    res_q   <= res_d;
                    carry_q <= c[4];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_NIB) begin
                        // Last slice: c[3] is the carry into the MSB, c[4] the carry out of it.
                        sum_q       <= res_d;
                        c_out_q     <= c[4];
                        ovf_q       <= c[3] ^ c[4];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Outputs keep their values after consumption; only the handshake drops.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_o     = sum_q;
    assign c_out     = c_out_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder: a WIDTH=16 instance driven with directed vectors,
// backpressure and mid-operation reset, plus a WIDTH=4 instance swept over all
// operand combinations. Expected results go into per-instance queues at the
// accepting edge; monitors pop and compare whenever a result is handed over.
module tb_serial_cla_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // WIDTH=16 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a_in, b_in, sum_o;
    logic        c_in, c_out, ovf_o;

    // WIDTH=4 instance
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a_in4, b_in4, sum_o4;
    logic        c_in4, c_out4, ovf_o4;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    int   checks = 0;
    int   errors = 0;
    logic bp_en = 1'b0;

    serial_cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_o(sum_o), .c_out(c_out), .ovf_o(ovf_o)
    );

    serial_cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a_in(a_in4), .b_in(b_in4), .c_in(c_in4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum_o(sum_o4), .c_out(c_out4), .ovf_o(ovf_o4)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result sign bits.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t        m;
        logic [16:0] full;
        logic [15:0] mask;
        mask   = 16'((32'd1 << w) - 1);
        full   = 17'(a) + 17'(b) + 17'(c);
        m.sum  = full[15:0] & mask;
        m.cout = full[w];
        m.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
        return m;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov);
        exp_t m;
        m.sum  = s;
        m.cout = co;
        m.ovf  = ov;
        return m;
    endfunction

    // Monitor for the 16-bit instance: compare on every handover
    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result16: got sum 0x%0h with nothing pending at %0t", sum_o, $time);
            end else begin
                e = exp_q.pop_front();
                check("result16", {14'd0, c_out, ovf_o, sum_o}, {14'd0, e.cout, e.ovf, e.sum});
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result4: got sum 0x%0h with nothing pending at %0t", sum_o4, $time);
            end else begin
                e = exp4_q.pop_front();
                check("result4", {26'd0, c_out4, ovf_o4, sum_o4}, {26'd0, e.cout, e.ovf, e.sum[3:0]});
            end
        end
    end

    // Random consumer stalls during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout16", {31'd0, in_ready}, 32'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = ~a;
        b_in = ~b;
        c_in = ~c;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c, input exp_t e);
        @(posedge clk);
        #1;
        in_valid4 = 1'b1;
        a_in4 = a;
        b_in4 = b;
        c_in4 = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready4) break;
        end
        if (!in_ready4) check("accept_timeout4", {31'd0, in_ready4}, 32'd1);
        else exp4_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        a_in4 = ~a;
        b_in4 = ~b;
        c_in4 = ~c;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && exp4_q.size() == 0) break;
        end
        check(name, exp_q.size() + exp4_q.size(), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [15:0] ra, rb;
        logic        rc;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; c_in = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a_in4 = '0; b_in4 = '0; c_in4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {14'd0, c_out, ovf_o, sum_o}, 32'd0);
        check("reset4_in_ready", {31'd0, in_ready4}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First transaction: latency and in_ready return
        send16(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cnt = i;
                break;
            end
        end
        check("latency_edges", cnt, 32'd4);
        @(posedge clk);
        #1;
        check("in_ready_after_result", {31'd0, in_ready}, 32'd1);
        check("out_valid_dropped", {31'd0, out_valid}, 32'd0);

        // Directed vectors with hand-computed results
        send16(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send16(16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        send16(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send16(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1));
        send16(16'h0000, 16'h0000, 1'b0, mk(16'h0000, 1'b0, 1'b0));
        send16(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        send16(16'h0FFF, 16'hF000, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        send16(16'h8000, 16'hFFFF, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
        send16(16'h1111, 16'h2222, 1'b1, mk(16'h3334, 1'b0, 1'b0));
        send16(16'hABCD, 16'h1234, 1'b0, mk(16'hBE01, 1'b0, 1'b0));
        send16(16'h7FFF, 16'h7FFF, 1'b1, mk(16'hFFFF, 1'b0, 1'b1));
        send16(16'hFFFF, 16'hFFFF, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));
        drain("drain_directed");

        // Backpressure: result held while out_ready is low, input blocked
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send16(16'hA5A5, 16'h5A5A, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in = 16'h0003;
        b_in = 16'h0004;
        c_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {14'd0, c_out, ovf_o, sum_o}, {14'd0, 1'b0, 1'b0, 16'hFFFF});
            check("bp_in_blocked", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_accept_on_consume", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("bp_reaccept", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back(mk(16'h0007, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("drain_bp");

        // Reset in the second ADD cycle discards the operation
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in = 16'h1111;
        b_in = 16'h2222;
        c_in = 1'b0;
        @(negedge clk);
        check("rst_pre_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {14'd0, c_out, ovf_o, sum_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send16(16'h0003, 16'h0004, 1'b0, mk(16'h0007, 1'b0, 1'b0));
        drain("drain_after_reset");

        // Random operands with random gaps and consumer stalls
        bp_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            send16(ra, rb, rc, model(16, ra, rb, rc));
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("drain_random");

        // Exhaustive sweep of the 4-bit instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    send4(4'(a), 4'(b), 1'(c), model(4, 16'(a), 16'(b), 1'(c)));
                end
            end
        end
        drain("drain_sweep4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
